// File: rtl/icache_line_responder.sv
// Direct-mapped, read-only instruction cache with a flip-flop line array; refills one 256-bit line at a time.
// Hit: ufp_resp 2 cycles after acceptance. Miss: adds the refill time plus one re-lookup cycle. Holds dfp_read until dfp_resp.
// Optional hit/miss counters are built only when ICACHE_PERF_CNT_EN is defined.
module icache_line_responder #(
    parameter int SETS = 16,
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  ufp_addr,
    input  logic         ufp_read,
    output logic [31:0]  ufp_rdata,
    output logic [255:0] ufp_rdata_line,
    output logic         ufp_resp,
    output logic [31:0]  dfp_addr,
    output logic         dfp_read,
    input  logic [255:0] dfp_rdata,
    input  logic         dfp_resp
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);

    localparam int TAG_W = 27 - IDX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL} state_t;

    state_t         state_q, state_d;
    logic [31:0]    req_addr_q, req_addr_d;
    logic           ufp_resp_q, ufp_resp_d;
    logic [31:0]    ufp_rdata_q, ufp_rdata_d;
    logic [255:0]   ufp_rdata_line_q, ufp_rdata_line_d;
    logic           dfp_read_q, dfp_read_d;
    logic [31:0]    dfp_addr_q, dfp_addr_d;
    logic [SETS-1:0] valid_q, valid_d;

    logic [TAG_W-1:0] tag_q  [SETS];
    logic [255:0]     data_q [SETS];

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      line_addr;
    logic [7:0]       word_lsb;
    logic [255:0]     hit_line;
    logic             hit;
    logic             fill_we;
    logic             unused_req_bits;

    assign req_idx   = req_addr_q[5 +: IDX_W];
    assign req_tag   = req_addr_q[31 -: TAG_W];
    assign line_addr = {req_addr_q[31:5], 5'b0};
    assign word_lsb  = {req_addr_q[4:2], 5'b0};
    assign hit_line  = data_q[req_idx];
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    // Byte offset within the word is irrelevant to a word-granular fetch.
    assign unused_req_bits = ^req_addr_q[1:0];

    always_comb begin
        state_d          = state_q;
        req_addr_d       = req_addr_q;
        valid_d          = valid_q;
        ufp_resp_d       = 1'b0;
        ufp_rdata_d      = 32'b0;
        ufp_rdata_line_d = 256'b0;
        dfp_read_d       = 1'b0;
        dfp_addr_d       = 32'b0;
        fill_we          = 1'b0;
        case (state_q)
            IDLE: begin
                // The response cycle is spent back in IDLE; the held request is taken next cycle.
                if (ufp_read && !ufp_resp_q) begin
                    req_addr_d = ufp_addr;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!ufp_read) begin
                    state_d = IDLE;
                end else if (hit) begin
                    ufp_resp_d       = 1'b1;
                    ufp_rdata_d      = hit_line[word_lsb +: 32];
                    ufp_rdata_line_d = hit_line;
                    state_d          = IDLE;
                end else begin
                    dfp_read_d = 1'b1;
                    dfp_addr_d = line_addr;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (dfp_resp) begin
                    fill_we          = !rst;
                    valid_d[req_idx] = 1'b1;
                    state_d          = LOOKUP;
                end else begin
                    dfp_read_d = 1'b1;
                    dfp_addr_d = line_addr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            req_addr_q       <= 32'b0;
            valid_q          <= '0;
            ufp_resp_q       <= 1'b0;
            ufp_rdata_q      <= 32'b0;
            ufp_rdata_line_q <= 256'b0;
            dfp_read_q       <= 1'b0;
            dfp_addr_q       <= 32'b0;
        end else begin
            state_q          <= state_d;
            req_addr_q       <= req_addr_d;
            valid_q          <= valid_d;
            ufp_resp_q       <= ufp_resp_d;
            ufp_rdata_q      <= ufp_rdata_d;
            ufp_rdata_line_q <= ufp_rdata_line_d;
            dfp_read_q       <= dfp_read_d;
            dfp_addr_q       <= dfp_addr_d;
        end
    end

    // Tag and data storage carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[req_idx]  <= req_tag;
            data_q[req_idx] <= dfp_rdata;
        end
    end

    assign ufp_resp       = ufp_resp_q;
    assign ufp_rdata      = ufp_rdata_q;
    assign ufp_rdata_line = ufp_rdata_line_q;
    assign dfp_read       = dfp_read_q;
    assign dfp_addr       = dfp_addr_q;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        prev_fill_q, prev_fill_d;

    // The lookup that follows a refill is neither a hit nor a miss.
    always_comb begin
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        prev_fill_d = (state_q == FILL);
        if (state_q == LOOKUP && ufp_read) begin
            if (!hit) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end else if (!prev_fill_q) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q   <= 32'b0;
            miss_cnt_q  <= 32'b0;
            prev_fill_q <= 1'b0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            prev_fill_q <= prev_fill_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_line_responder.sv
// Directed bench for icache_line_responder: cold miss, hit, conflict, back-to-back, reset mid-refill, optional counters.
module tb_icache_line_responder;

    logic         clk;
    logic         rst;
    logic [31:0]  ufp_addr;
    logic         ufp_read;
    logic [31:0]  ufp_rdata;
    logic [255:0] ufp_rdata_line;
    logic         ufp_resp;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    icache_line_responder #(.SETS(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .ufp_addr       (ufp_addr),
        .ufp_read       (ufp_read),
        .ufp_rdata      (ufp_rdata),
        .ufp_rdata_line (ufp_rdata_line),
        .ufp_resp       (ufp_resp),
        .dfp_addr       (dfp_addr),
        .dfp_read       (dfp_read),
        .dfp_rdata      (dfp_rdata),
        .dfp_resp       (dfp_resp)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Refill contents: word i of line LA is LA ^ 0x5A00_0000 + 4*i, except word1 of line 0x1000.
    function automatic logic [255:0] mk_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = (la ^ 32'h5A00_0000) + 32'(i * 4);
        if (la == 32'h0000_1000) l[63:32] = 32'hDEAD_BEEF;
        return l;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ufp_read = 1'b0; dfp_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge where ufp_resp is seen (or after a timeout).
    task automatic request(input string name, input logic [31:0] addr, input bit keep,
                           input bit exp_miss, input int base_lat, input bit scramble);
        logic [255:0] exp_line;
        logic [7:0]   off;
        logic [31:0]  exp_word;
        int k, fills, fill_cyc;
        bit got, nonzero;
        exp_line = mk_line({addr[31:5], 5'b0});
        off      = {addr[4:2], 5'b0};
        exp_word = exp_line[off +: 32];
        ufp_addr = addr;
        ufp_read = 1'b1;
        k = 0; fills = 0; fill_cyc = 0; got = 1'b0; nonzero = 1'b0;
        while (!got && k < 60) begin
            @(negedge clk);
            k++;
            if (scramble && k == 1) ufp_addr = addr ^ 32'hFFFF_0000;
            if (ufp_resp) got = 1'b1;
            else if (ufp_rdata != 32'b0 || ufp_rdata_line != 256'b0) nonzero = 1'b1;
            if (dfp_resp) dfp_resp = 1'b0;
            if (dfp_read) begin
                fill_cyc++;
                if (fill_cyc == 1) begin
                    fills++;
                    check({name, "_dfp_addr"}, 256'(dfp_addr), 256'({addr[31:5], 5'b0}));
                end else if (fill_cyc == 2) begin
                    dfp_rdata = exp_line;
                    dfp_resp  = 1'b1;
                end
            end
        end
        check({name, "_resp_seen"}, 256'(got), 256'(1));
        if (got) begin
            check({name, "_rdata"}, 256'(ufp_rdata), 256'(exp_word));
            check({name, "_line"}, ufp_rdata_line, exp_line);
            check({name, "_latency"}, 256'(k), 256'(base_lat + (fill_cyc > 0 ? fill_cyc + 1 : 0)));
        end
        check({name, "_fills"}, 256'(fills), 256'(exp_miss));
        check({name, "_zero_when_idle"}, 256'(nonzero), 256'(0));
        ufp_addr = addr;
        if (!keep) ufp_read = 1'b0;
    endtask

    initial begin
        bit seen;
        int n;
        rst = 1'b0; ufp_addr = 32'b0; ufp_read = 1'b0; dfp_rdata = 256'b0; dfp_resp = 1'b0;
        do_reset();

        check("rst_ufp_resp", 256'(ufp_resp), 256'(0));
        check("rst_dfp_read", 256'(dfp_read), 256'(0));
        check("rst_ufp_rdata", 256'(ufp_rdata), 256'(0));
        check("rst_line", ufp_rdata_line, 256'b0);
        check("rst_dfp_addr", 256'(dfp_addr), 256'(0));

        request("cold", 32'h0000_1004, 1'b0, 1'b1, 2, 1'b0);
        check("cold_deadbeef", 256'(ufp_rdata), 256'(32'hDEAD_BEEF));
        @(negedge clk);
        request("hit", 32'h0000_101C, 1'b0, 1'b0, 2, 1'b1);
`ifdef ICACHE_PERF_CNT_EN
        @(negedge clk);
        check("perf_miss_cnt", 256'(miss_cnt), 256'(1));
        check("perf_hit_cnt", 256'(hit_cnt), 256'(1));
`endif

        // Conflict: 0x1000 and 0x1200 share index 0 with different tags.
        do_reset();
        request("conf_a", 32'h0000_1000, 1'b0, 1'b1, 2, 1'b0);
        @(negedge clk);
        request("conf_b", 32'h0000_1200, 1'b0, 1'b1, 2, 1'b0);
        @(negedge clk);
        request("conf_c", 32'h0000_1000, 1'b0, 1'b1, 2, 1'b0);

        // Back-to-back with ufp_read held across four words of one line.
        @(negedge clk);
        request("b2b0", 32'h0000_2000, 1'b1, 1'b1, 2, 1'b0);
        request("b2b1", 32'h0000_2004, 1'b1, 1'b0, 3, 1'b0);
        request("b2b2", 32'h0000_2008, 1'b1, 1'b0, 3, 1'b0);
        request("b2b3", 32'h0000_200C, 1'b0, 1'b0, 3, 1'b0);

        // Reset during a refill, then a stale dfp_resp.
        @(negedge clk);
        ufp_addr = 32'h0000_3000; ufp_read = 1'b1;
        seen = 1'b0; n = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            seen = dfp_read;
        end
        check("midfill_dfp_read_seen", 256'(seen), 256'(1));
        rst = 1'b1; ufp_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midfill_dfp_read_after_rst", 256'(dfp_read), 256'(0));
        dfp_rdata = mk_line(32'h0000_3000); dfp_resp = 1'b1;
        @(negedge clk);
        dfp_resp = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ufp_resp || dfp_read) seen = 1'b1;
            @(negedge clk);
        end
        check("midfill_quiet", 256'(seen), 256'(0));
        request("midfill_retry", 32'h0000_3000, 1'b0, 1'b1, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_line_responder.md
Name: icache_line_responder

Overview:
- Direct-mapped instruction cache that sits below the fetch-side prefetcher.
- Acts as the responder on the fetch request interface: accepts read requests, returns both the addressed 32-bit word and the full 256-bit line.
- Refills from memory through a 256-bit line-granular downstream port.
- Storage is a flip-flop array, no SRAM macros.

Parameters:
- SETS, 16: number of lines; power of two, 2..64.
- IDX_W, $clog2(SETS): index width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ufp_addr  in  32  request byte address; held stable by requester until ufp_resp
- ufp_read  in  1  request valid; held high until ufp_resp
- ufp_rdata  out  32  word at ufp_addr[4:2] of the line
- ufp_rdata_line  out  256  full line containing ufp_addr
- ufp_resp  out  1  single-cycle response pulse
- dfp_addr  out  32  line-aligned refill address
- dfp_read  out  1  refill request; held until dfp_resp
- dfp_rdata  in  256  refill line data
- dfp_resp  in  1  refill complete, single-cycle

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- On reset:
  - All valid bits clear, state is IDLE.
  - ufp_resp, dfp_read, ufp_rdata, ufp_rdata_line, dfp_addr are all 0.
  - Tag and data arrays are not reset.
- Address split: offset [4:0], index [4+IDX_W:5], tag [31:5+IDX_W].
- States:
  - IDLE: if ufp_read, latch ufp_addr into req_addr and go to LOOKUP.
  - LOOKUP: hit = valid[idx] and tag match.
    - Hit: ufp_resp=1, drive data from the array, go to IDLE.
    - Miss: go to FILL.
  - FILL: dfp_read=1, dfp_addr={req_addr[31:5],5'b0}, held constant.
    - On dfp_resp: write line, tag, valid=1 at idx; go to LOOKUP, which then hits.
- Latency:
  - Hit: ufp_resp 2 cycles after ufp_read is first seen high (accept cycle plus LOOKUP).
  - Miss: 2 + memory latency + 1.
- ufp_read is ignored in the ufp_resp cycle. The cache returns to IDLE and the next request is accepted the following cycle. The requester holds its request, so nothing is lost.
- ufp_rdata and ufp_rdata_line are 0 in every cycle where ufp_resp=0.
- ufp_rdata selects bits [req_addr[4:2]*32 +: 32]; ufp_addr[1:0] is ignored.
- Changes to ufp_addr after acceptance are ignored; req_addr is used throughout.
- If ufp_read drops during FILL:
  - The fill completes and the line is installed.
  - The FSM then goes to IDLE with no ufp_resp.
  - Checked in LOOKUP: if ufp_read=0, go to IDLE with no response.
- dfp_resp while not in FILL is ignored, e.g. a stale response after a mid-refill reset.
- Reset mid-FILL: dfp_read=0 the cycle after rst; no array write occurs.
- A conflicting line at the same index is overwritten; there is no writeback because the cache is read-only.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], reset to 0, wrapping modulo 2^32.
  - miss_cnt increments on each LOOKUP to FILL transition.
  - hit_cnt increments on a LOOKUP hit only when the previous state was not FILL, so post-refill lookups count as neither hit nor miss.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss: after reset, ufp_read=1, ufp_addr=0x0000_1004.
  - dfp_read=1 with dfp_addr=0x0000_1000.
  - Return dfp_rdata with word1=0xDEAD_BEEF and dfp_resp one cycle later.
  - Expect ufp_resp 1 cycle after dfp_resp, ufp_rdata=0xDEAD_BEEF, ufp_rdata_line equal to the refill line.
- Hit: ufp_addr=0x0000_101C after the above.
  - ufp_resp 2 cycles after request, word7 returned.
  - No dfp_read asserted.
- Conflict: with SETS=16, request 0x0000_1000 then 0x0000_1200 (same index, different tag) then 0x0000_1000.
  - Three refills are issued; each response matches its own refill data.
- Back-to-back: ufp_read held high across 4 sequential addresses 0x2000..0x200C, all in the same line.
  - One refill, then responses 3 cycles apart (resp cycle, IDLE accept, LOOKUP); no request lost.
- Reset mid-FILL: assert rst for 1 cycle while dfp_read=1, then pulse dfp_resp.
  - dfp_read=0 after reset; no ufp_resp.
  - The next request to the same address misses again.
- With ICACHE_PERF_CNT_EN: run the cold-miss and hit scenarios.
  - Expect miss_cnt=1, hit_cnt=1.
